// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, op codes and op-decode helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    localparam logic [4:0] OP_LB  = 5'h10;
    localparam logic [4:0] OP_LH  = 5'h11;
    localparam logic [4:0] OP_LW  = 5'h12;
    localparam logic [4:0] OP_LBU = 5'h13;
    localparam logic [4:0] OP_LHU = 5'h14;
    localparam logic [4:0] OP_SB  = 5'h18;
    localparam logic [4:0] OP_SH  = 5'h19;
    localparam logic [4:0] OP_SW  = 5'h1A;

    function automatic logic is_load(input logic [4:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_unsigned(input logic [4:0] op);
        return (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic mem_size_t size_of(input logic [4:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return BYTE;
            OP_LH, OP_LHU, OP_SH: return HALF;
            default:              return WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - picks the addressed byte/half lane out of a load word and extends it
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  mem_size_t   size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (size_i)
            BYTE:    data_o = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            HALF:    data_o = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory stage: req/gnt/rvalid data port master with lane alignment and watchdog
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_mem_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    input  logic        dmem_gnt,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        st_done,
    output logic        exc_misalign,
    output logic        exc_buserr,
    output logic [31:0] exc_addr
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic             WDOG_EN     = (TIMEOUT_CYCLES != 0);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] wdog_q, wdog_d, wdog_inc;
    logic             drop_q, drop_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      eaddr_q, eaddr_d;
    mem_size_t        size_q, size_d;
    logic             uns_q, uns_d;
    logic [4:0]       rd_q, rd_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             st_done_q, st_done_d;
    logic             mis_q, mis_d;
    logic             bus_q, bus_d;
    logic [31:0]      exc_addr_q, exc_addr_d;

    logic             is_mem_op;
    logic             misaligned;
    logic             timeout;
    mem_size_t        ex_size;
    logic [3:0]       st_strb;
    logic [31:0]      st_data;
    logic [31:0]      ld_data;

    assign ex_size    = size_of(ex_mem_op);
    assign is_mem_op  = is_load(ex_mem_op) || is_store(ex_mem_op);
    assign misaligned = ((ex_size == HALF) && ex_addr[0]) ||
                        ((ex_size == WORD) && (ex_addr[1:0] != 2'b00));
    assign wdog_inc   = wdog_q + CNT_W'(1);
    // Compare against the incremented count so req is held for exactly TIMEOUT_CYCLES cycles.
    assign timeout    = WDOG_EN && (wdog_inc >= TIMEOUT_VAL);

    always_comb begin
        st_strb = 4'b0000;
        st_data = 32'd0;
        if (is_store(ex_mem_op)) begin
            case (ex_size)
                BYTE: begin
                    st_strb = 4'b0001 << ex_addr[1:0];
                    st_data = {4{ex_wdata[7:0]}};
                end
                HALF: begin
                    st_strb = 4'b0011 << {ex_addr[1], 1'b0};
                    st_data = {2{ex_wdata[15:0]}};
                end
                default: begin
                    st_strb = 4'b1111;
                    st_data = ex_wdata;
                end
            endcase
        end
    end

    lsu_load_align u_load_align (
        .rdata_i    (dmem_rdata),
        .addr_lo_i  (eaddr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        drop_d     = drop_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        eaddr_d    = eaddr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        st_done_d  = 1'b0;
        mis_d      = 1'b0;
        bus_d      = 1'b0;
        exc_addr_d = exc_addr_q;

        case (state_q)
            IDLE: begin
                if (ex_valid && is_mem_op && !flush) begin
                    if (misaligned) begin
                        mis_d      = 1'b1;
                        exc_addr_d = ex_addr;
                    end else begin
                        state_d = REQ;
                        wdog_d  = '0;
                        drop_d  = 1'b0;
                        req_d   = 1'b1;
                        we_d    = is_store(ex_mem_op);
                        addr_d  = {ex_addr[31:2], 2'b00};
                        wstrb_d = st_strb;
                        wdata_d = st_data;
                        eaddr_d = ex_addr;
                        size_d  = ex_size;
                        uns_d   = is_unsigned(ex_mem_op);
                        rd_d    = ex_rd;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        st_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = RESP;
                        drop_d  = flush;
                        wdog_d  = wdog_inc;
                    end
                end else if (flush) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (timeout) begin
                    req_d      = 1'b0;
                    state_d    = IDLE;
                    bus_d      = 1'b1;
                    exc_addr_d = eaddr_q;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            RESP: begin
                drop_d = drop_q | flush;
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    if (!(drop_q || flush)) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = ld_data;
                    end
                end else if (timeout) begin
                    state_d    = IDLE;
                    bus_d      = 1'b1;
                    exc_addr_d = eaddr_q;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wdog_q     <= '0;
            drop_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wstrb_q    <= 4'd0;
            wdata_q    <= 32'd0;
            eaddr_q    <= 32'd0;
            size_q     <= BYTE;
            uns_q      <= 1'b0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            st_done_q  <= 1'b0;
            mis_q      <= 1'b0;
            bus_q      <= 1'b0;
            exc_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            drop_q     <= drop_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            eaddr_q    <= eaddr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            st_done_q  <= st_done_d;
            mis_q      <= mis_d;
            bus_q      <= bus_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    assign ex_ready     = (state_q == IDLE);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wstrb   = wstrb_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign st_done      = st_done_q;
    assign exc_misalign = mis_q;
    assign exc_buserr   = bus_q;
    assign exc_addr     = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_mem_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        dmem_req;
    logic        dmem_gnt;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done;
    logic        exc_misalign;
    logic        exc_buserr;
    logic [31:0] exc_addr;

    int n_assert = 0;
    int n_fail   = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_mem_op    (ex_mem_op),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .dmem_req     (dmem_req),
        .dmem_gnt     (dmem_gnt),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_wdata   (dmem_wdata),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .st_done      (st_done),
        .exc_misalign (exc_misalign),
        .exc_buserr   (exc_buserr),
        .exc_addr     (exc_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        ex_valid  = 1'b1;
        ex_mem_op = op;
        ex_addr   = a;
        ex_wdata  = d;
        ex_rd     = rd;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_mem_op = 5'd0; ex_addr = 32'd0;
        ex_wdata = 32'd0; ex_rd = 5'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        step(); step();
        chk("rst_ready", ex_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wb", wb_valid, 0);
        rst = 1'b0;
        step();

        // LB 0x1003: gnt in first REQ cycle, rvalid two cycles after gnt
        issue(OP_LB, 32'h0000_1003, 32'd0, 5'd5);
        chk("lb_ready_idle", ex_ready, 1);
        step();
        ex_valid = 1'b0;
        chk("lb_req", dmem_req, 1);
        chk("lb_we", dmem_we, 0);
        chk("lb_addr", dmem_addr, 32'h0000_1000);
        chk("lb_wstrb", dmem_wstrb, 0);
        chk("lb_ready_busy", ex_ready, 0);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("lb_req_drop", dmem_req, 0);
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_1234;
        step();
        dmem_rvalid = 1'b0;
        chk("lb_wb_valid", wb_valid, 1);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd", wb_rd, 5);
        chk("lb_ready_back", ex_ready, 1);

        // LBU same address: issued back-to-back on the wb cycle
        issue(OP_LBU, 32'h0000_1003, 32'd0, 5'd7);
        step();
        ex_valid = 1'b0;
        chk("lb_wb_pulse", wb_valid, 0);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        step();
        dmem_rvalid = 1'b1;
        step();
        dmem_rvalid = 1'b0;
        chk("lbu_wb_data", wb_data, 32'h0000_0080);
        chk("lbu_wb_rd", wb_rd, 7);

        // SH 0x2002, one wait cycle before gnt
        issue(OP_SH, 32'h0000_2002, 32'hDEAD_BEEF, 5'd0);
        step();
        ex_valid = 1'b0;
        chk("sh_addr", dmem_addr, 32'h0000_2000);
        chk("sh_wstrb", dmem_wstrb, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_we", dmem_we, 1);
        step();
        chk("sh_req_hold", dmem_req, 1);
        chk("sh_ready_wait", ex_ready, 0);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("sh_st_done", st_done, 1);
        chk("sh_ready", ex_ready, 1);
        chk("sh_req_off", dmem_req, 0);
        step();
        chk("sh_st_done_pulse", st_done, 0);

        // LW 0x3001 misaligned
        issue(OP_LW, 32'h0000_3001, 32'd0, 5'd3);
        step();
        ex_valid = 1'b0;
        chk("mis_pulse", exc_misalign, 1);
        chk("mis_addr", exc_addr, 32'h0000_3001);
        chk("mis_noreq", dmem_req, 0);
        chk("mis_ready", ex_ready, 1);
        step();
        chk("mis_pulse_end", exc_misalign, 0);
        chk("mis_noreq2", dmem_req, 0);

        // LW 0x4000 with no gnt: watchdog of 4 cycles
        issue(OP_LW, 32'h0000_4000, 32'd0, 5'd4);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("to_req_held", dmem_req, 1);
            step();
        end
        chk("to_req_last", dmem_req, 1);
        step();
        chk("to_buserr", exc_buserr, 1);
        chk("to_req_drop", dmem_req, 0);
        chk("to_exc_addr", exc_addr, 32'h0000_4000);
        chk("to_ready", ex_ready, 1);
        dmem_rvalid = 1'b1;
        step();
        dmem_rvalid = 1'b0;
        chk("to_buserr_end", exc_buserr, 0);
        chk("to_late_rvalid", wb_valid, 0);

        // LH at 0x1002 with minimum latency (accept, gnt, rvalid)
        issue(OP_LH, 32'h0000_1002, 32'd0, 5'd11);
        step();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_1234;
        step();
        dmem_rvalid = 1'b0;
        chk("lh_wb_valid", wb_valid, 1);
        chk("lh_wb_data", wb_data, 32'hFFFF_80FF);

        // LW 0x5000, flush while in RESP, then rvalid: dropped
        issue(OP_LW, 32'h0000_5000, 32'd0, 5'd9);
        step();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        step();
        dmem_rvalid = 1'b0;
        chk("fl_no_wb", wb_valid, 0);
        chk("fl_ready", ex_ready, 1);
        issue(OP_SB, 32'h0000_5001, 32'h0000_00A5, 5'd0);
        step();
        ex_valid = 1'b0;
        chk("fl_next_req", dmem_req, 1);
        chk("sb_wstrb", dmem_wstrb, 4'b0010);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("sb_st_done", st_done, 1);

        // Async reset while in RESP, then a fresh SW
        issue(OP_LHU, 32'h0000_6002, 32'd0, 5'd6);
        step();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("rr_in_resp", ex_ready, 0);
        rst = 1'b1;
        #1;
        chk("rr_async_ready", ex_ready, 1);
        chk("rr_async_addr", dmem_addr, 0);
        chk("rr_async_wb", wb_valid, 0);
        step();
        rst = 1'b0;
        issue(OP_SW, 32'h0000_7000, 32'h1234_5678, 5'd0);
        step();
        ex_valid = 1'b0;
        chk("sw_addr", dmem_addr, 32'h0000_7000);
        chk("sw_wstrb", dmem_wstrb, 4'b1111);
        chk("sw_wdata", dmem_wdata, 32'h1234_5678);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("sw_st_done", st_done, 1);
        step();
        chk("sw_st_done_end", st_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
